xoseram_bus_if: RTL and testbench

//  m68k bus-cycle front end for XoseRAM. It sits between the pad-registered bus pins (cs_n, rd_nwr,

---
 rtl/xoseram_bus_if_if.sv | 21 ++
 rtl/xoseram_bus_if.sv | 136 +++++++++++++
 tb/tb_xoseram_bus_if.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/xoseram_bus_if_if.sv
// 68k-side bus pins of the XoseRAM front end, grouped for the bus interface block.
// Handshake: CS low opens a bus cycle; DTACK low acknowledges it and stays low until CS is released.
interface xoseram_bus_if_if;
  logic       bus_cs_n_i;
  logic       bus_rd_nwr_i;
  logic       bus_bytesel_i;
  logic [3:0] bus_reg_num_i;
  logic [7:0] bus_data_i;
  logic [7:0] bus_data_o;
  logic       bus_dtack_n_o;

  modport master (
    output bus_cs_n_i, bus_rd_nwr_i, bus_bytesel_i, bus_reg_num_i, bus_data_i,
    input  bus_data_o, bus_dtack_n_o
  );

  modport slave (
    input  bus_cs_n_i, bus_rd_nwr_i, bus_bytesel_i, bus_reg_num_i, bus_data_i,
    output bus_data_o, bus_dtack_n_o
  );
endinterface

// File: rtl/xoseram_bus_if.sv
// m68k bus-cycle front end: syncs CS, settles, issues one register strobe per cycle, drives DTACK.
// Optional read timeout is enabled by defining XOSERAM_RD_TIMEOUT_EN.
module xoseram_bus_if #(
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 1,
  parameter int RD_TIMEOUT    = 64
) (
  input  logic            clk,
  input  logic            reset_n_i,
  xoseram_bus_if_if.slave bus,
  output logic            reg_wr_o,
  output logic            reg_rd_o,
  output logic [3:0]      reg_num_o,
  output logic            reg_bytesel_o,
  output logic [7:0]      reg_data_o,
  input  logic [7:0]      reg_rd_data_i,
  input  logic            reg_rd_valid_i,
  output logic            busy_o,
  output logic [2:0]      state_o
);

  typedef enum logic [2:0] {IDLE, SETTLE, WSTB, RSTB, RWAIT, ACK} state_t;

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  if (SYNC_STAGES < 2 || SETTLE_CYCLES < 1 || RD_TIMEOUT < 1) begin : g_bad_params
    $error("xoseram_bus_if: parameter out of range");
  end

  state_t                 state;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SW-1:0]          settle_cnt;
  logic                   cs_act;

  assign cs_act  = ~cs_sync[SYNC_STAGES-1];
  assign state_o = state;

`ifdef XOSERAM_RD_TIMEOUT_EN
  localparam int TW = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
  logic [TW-1:0] to_cnt;
`endif

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cs_sync           <= '1;
      state             <= IDLE;
      settle_cnt        <= '0;
      bus.bus_dtack_n_o <= 1'b1;
      bus.bus_data_o    <= '0;
      reg_wr_o          <= 1'b0;
      reg_rd_o          <= 1'b0;
      reg_num_o         <= '0;
      reg_bytesel_o     <= 1'b0;
      reg_data_o        <= '0;
      busy_o            <= 1'b0;
`ifdef XOSERAM_RD_TIMEOUT_EN
      to_cnt            <= '0;
`endif
    end else begin
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], bus.bus_cs_n_i};
      reg_wr_o <= 1'b0;
      reg_rd_o <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_act) begin
            state      <= SETTLE;
            busy_o     <= 1'b1;
            settle_cnt <= SW'(SETTLE_CYCLES - 1);
          end
        end
        SETTLE: begin
          if (!cs_act) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else if (settle_cnt != '0) begin
            settle_cnt <= settle_cnt - SW'(1);
          end else begin
            // Bus fields are stable by now; later changes are ignored until the next cycle.
            reg_num_o     <= bus.bus_reg_num_i;
            reg_bytesel_o <= bus.bus_bytesel_i;
            reg_data_o    <= bus.bus_data_i;
            if (bus.bus_rd_nwr_i) begin
              state    <= RSTB;
              reg_rd_o <= 1'b1;
            end else begin
              state    <= WSTB;
              reg_wr_o <= 1'b1;
            end
          end
        end
        WSTB: begin
          state             <= ACK;
          bus.bus_dtack_n_o <= 1'b0;
        end
        RSTB: begin
          state <= RWAIT;
`ifdef XOSERAM_RD_TIMEOUT_EN
          to_cnt <= '0;
`endif
        end
        RWAIT: begin
          if (reg_rd_valid_i) begin
            bus.bus_data_o    <= reg_rd_data_i;
            bus.bus_dtack_n_o <= 1'b0;
            state             <= ACK;
          end else if (!cs_act) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
`ifdef XOSERAM_RD_TIMEOUT_EN
          else if (to_cnt == TW'(RD_TIMEOUT - 1)) begin
            bus.bus_data_o    <= 8'hFF;
            bus.bus_dtack_n_o <= 1'b0;
            state             <= ACK;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
`endif
        end
        ACK: begin
          if (!cs_act) begin
            state             <= IDLE;
            busy_o            <= 1'b0;
            bus.bus_dtack_n_o <= 1'b1;
          end
        end
        default: begin
          state             <= IDLE;
          busy_o            <= 1'b0;
          bus.bus_dtack_n_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xoseram_bus_if.sv
// Scoreboard bench for xoseram_bus_if: tasks drive 68k bus cycles and push timed expected events;
// a negedge monitor pops and compares each strobe, DTACK fall and DTACK rise.
module tb_xoseram_bus_if;

  localparam int W = 47;
  localparam logic [1:0] EV_WR = 2'd0, EV_RD = 2'd1, EV_ACK = 2'd2, EV_REL = 2'd3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       reg_wr, reg_rd, reg_bytesel, reg_rd_valid, busy;
  logic [3:0] reg_num;
  logic [7:0] reg_data, reg_rd_data;
  logic [2:0] state_dbg;

  xoseram_bus_if_if bus ();

  xoseram_bus_if dut (
    .clk           (clk),
    .reset_n_i     (reset_n),
    .bus           (bus),
    .reg_wr_o      (reg_wr),
    .reg_rd_o      (reg_rd),
    .reg_num_o     (reg_num),
    .reg_bytesel_o (reg_bytesel),
    .reg_data_o    (reg_data),
    .reg_rd_data_i (reg_rd_data),
    .reg_rd_valid_i(reg_rd_valid),
    .busy_o        (busy),
    .state_o       (state_dbg)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0] exp_q[$];
  int   total = 0;
  int   bad   = 0;
  logic [7:0] model_data = 8'h00;
  logic prev_dtack = 1'b1;

  function automatic logic [W-1:0] ev(input logic [1:0] k, input int cy, input logic [3:0] rn,
                                       input logic bs, input logic [7:0] d);
    return {k, 32'(cy), rn, bs, d};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_event(input logic [W-1:0] act);
    logic [W-1:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: got kind=%0d cyc=%0d rn=%h bs=%b d=%h, expected nothing",
               act[46:45], act[44:13], act[12:9], act[8], act[7:0]);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        bad++;
        $display("FAIL event: got kind=%0d cyc=%0d rn=%h bs=%b d=%h, expected kind=%0d cyc=%0d rn=%h bs=%b d=%h",
                 act[46:45], act[44:13], act[12:9], act[8], act[7:0],
                 e[46:45], e[44:13], e[12:9], e[8], e[7:0]);
      end
    end
  endtask

  // Monitor: every observable DUT event must match the head of the expected queue.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_dtack = 1'b1;
    end else begin
      if (reg_wr) check_event(ev(EV_WR, cyc, reg_num, reg_bytesel, reg_data));
      if (reg_rd) check_event(ev(EV_RD, cyc, reg_num, reg_bytesel, 8'h00));
      if (!bus.bus_dtack_n_o && prev_dtack)
        check_event(ev(EV_ACK, cyc, reg_num, reg_bytesel, bus.bus_data_o));
      if (bus.bus_dtack_n_o && !prev_dtack) check_event(ev(EV_REL, cyc, 4'h0, 1'b0, 8'h00));
      prev_dtack = bus.bus_dtack_n_o;
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_cycle(input logic rd, input logic [3:0] rn, input logic bs, input logic [7:0] d);
    bus.bus_rd_nwr_i  = rd;
    bus.bus_reg_num_i = rn;
    bus.bus_bytesel_i = bs;
    bus.bus_data_i    = d;
    bus.bus_cs_n_i    = 1'b0;
  endtask

  task automatic release_cs(input logic acked, input int gap);
    bus.bus_cs_n_i = 1'b1;
    if (acked) exp_q.push_back(ev(EV_REL, cyc + 3, 4'h0, 1'b0, 8'h00));
    wait_cyc(cyc + gap);
  endtask

  // Synced CS is active 2 cycles after the drive cycle c; with S=1 the strobe lands at c+4.
  task automatic do_write(input logic [3:0] rn, input logic bs, input logic [7:0] d,
                          input int hold, input int gap);
    int c;
    c = cyc;
    start_cycle(1'b0, rn, bs, d);
    exp_q.push_back(ev(EV_WR, c + 4, rn, bs, d));
    exp_q.push_back(ev(EV_ACK, c + 5, rn, bs, model_data));
    wait_cyc(c + 5);
    bus.bus_reg_num_i = 4'($urandom);
    bus.bus_data_i    = 8'($urandom);
    bus.bus_bytesel_i = 1'($urandom);
    bus.bus_rd_nwr_i  = 1'($urandom);
    wait_cyc(c + 5 + hold);
    release_cs(1'b1, gap);
  endtask

  // vd > 0: valid arrives vd cycles after reg_rd_o; vd <= 0: no valid at all.
  task automatic do_read(input logic [3:0] rn, input logic bs, input int vd, input logic [7:0] rdata,
                         input int hold, input int gap);
    int c, r;
    logic acked;
    c = cyc;
    r = c + 4;
    acked = 1'b1;
    start_cycle(1'b1, rn, bs, 8'($urandom));
    exp_q.push_back(ev(EV_RD, r, rn, bs, 8'h00));
    if (vd > 0) begin
      wait_cyc(r + vd);
      reg_rd_valid = 1'b1;
      reg_rd_data  = rdata;
      model_data   = rdata;
      exp_q.push_back(ev(EV_ACK, r + vd + 1, rn, bs, rdata));
      wait_cyc(r + vd + 1);
      reg_rd_valid = 1'b0;
      reg_rd_data  = 8'($urandom);
      wait_cyc(r + vd + 1 + hold);
    end else begin
`ifdef XOSERAM_RD_TIMEOUT_EN
      model_data = 8'hFF;
      exp_q.push_back(ev(EV_ACK, r + 65, rn, bs, 8'hFF));
      wait_cyc(r + 65 + hold);
`else
      wait_cyc(r + 1000);
      chk("no_timeout_dtack", 32'(bus.bus_dtack_n_o), 32'd1);
      acked = 1'b0;
`endif
    end
    release_cs(acked, gap);
  endtask

  task automatic abort_settle(input int gap);
    start_cycle(1'($urandom), 4'($urandom), 1'($urandom), 8'($urandom));
    wait_cyc(cyc + 1);
    release_cs(1'b0, gap);
  endtask

  // CS drops while waiting for read data; a later valid must not reach the bus.
  task automatic abort_rwait(input logic [3:0] rn, input int k, input logic [7:0] late);
    int r;
    r = cyc + 4;
    start_cycle(1'b1, rn, 1'b0, 8'h00);
    exp_q.push_back(ev(EV_RD, r, rn, 1'b0, 8'h00));
    wait_cyc(r + k);
    bus.bus_cs_n_i = 1'b1;
    wait_cyc(r + k + 4);
    reg_rd_valid = 1'b1;
    reg_rd_data  = late;
    wait_cyc(r + k + 5);
    reg_rd_valid = 1'b0;
    wait_cyc(r + k + 6);
    chk("abort_rwait_data", 32'(bus.bus_data_o), 32'(model_data));
    chk("abort_rwait_dtack", 32'(bus.bus_dtack_n_o), 32'd1);
  endtask

  task automatic reset_in_ack(input logic [3:0] rn, input logic [7:0] d);
    int c, dr;
    c = cyc;
    start_cycle(1'b0, rn, 1'b1, d);
    exp_q.push_back(ev(EV_WR, c + 4, rn, 1'b1, d));
    exp_q.push_back(ev(EV_ACK, c + 5, rn, 1'b1, model_data));
    wait_cyc(c + 6);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_dtack", 32'(bus.bus_dtack_n_o), 32'd1);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_reg_num", 32'(reg_num), 32'd0);
    wait_cyc(c + 9);
    reset_n    = 1'b1;
    model_data = 8'h00;
    dr = cyc;
    exp_q.push_back(ev(EV_WR, dr + 4, rn, 1'b1, d));
    exp_q.push_back(ev(EV_ACK, dr + 5, rn, 1'b1, 8'h00));
    wait_cyc(dr + 6);
    release_cs(1'b1, 2);
  endtask

  initial begin
    reset_n           = 1'b0;
    bus.bus_cs_n_i    = 1'b1;
    bus.bus_rd_nwr_i  = 1'b0;
    bus.bus_bytesel_i = 1'b0;
    bus.bus_reg_num_i = 4'h0;
    bus.bus_data_i    = 8'h00;
    reg_rd_data       = 8'h00;
    reg_rd_valid      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dtack", 32'(bus.bus_dtack_n_o), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr", 32'(reg_wr), 32'd0);
    chk("rst_rd", 32'(reg_rd), 32'd0);
    chk("rst_bus_data", 32'(bus.bus_data_o), 32'd0);
    chk("rst_reg_num", 32'(reg_num), 32'd0);
    chk("rst_reg_data", 32'(reg_data), 32'd0);
    chk("rst_bytesel", 32'(reg_bytesel), 32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    do_write(4'h3, 1'b0, 8'hA5, 2, 2);
    do_read(4'h9, 1'b1, 3, 8'h5C, 1, 2);
    abort_settle(3);
    chk("abort_settle_busy", 32'(busy), 32'd0);
    abort_rwait(4'h6, 2, 8'h77);
    do_write(4'h1, 1'b0, 8'h11, 0, 1);
    do_write(4'h2, 1'b1, 8'h22, 0, 1);
    do_write(4'h4, 1'b0, 8'h33, 20, 2);
    reset_in_ack(4'hC, 8'h6D);
    do_read(4'h7, 1'b0, 0, 8'h00, 1, 2);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: do_write(4'($urandom), 1'($urandom), 8'($urandom),
                             $urandom_range(0, 5), $urandom_range(1, 4));
        4, 5, 6, 7: do_read(4'($urandom), 1'($urandom), $urandom_range(1, 6), 8'($urandom),
                            $urandom_range(0, 5), $urandom_range(1, 4));
        8:          abort_settle($urandom_range(1, 4));
        default:    abort_rwait(4'($urandom), $urandom_range(1, 5), 8'($urandom));
      endcase
    end

    wait_cyc(cyc + 10);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("final_busy", 32'(busy), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
